// File: rtl/inst_fetch_queue.sv
`timescale 1ns/1ps
// inst_fetch_queue
//   Instruction queue between fetch and decode. Issues memory requests for
//   fetch PCs, tracks up to MAX_OUTSTANDING in-flight requests, and buffers
//   returned instructions (tagged with pc/exception) in a DEPTH-entry FIFO.
//   A flush empties the FIFO and marks every in-flight request as "to discard"
//   so that late responses from the cancelled path are silently dropped.
// Ports
//   clk, reset                      clock, async active-high reset
//   pc_valid_i/pc_i/pc_exc_i/
//   pc_exccode_i/pc_ready_o         fetch side PC handshake
//   inst_req_o/inst_addr_o/
//   inst_addr_ok_i/inst_data_ok_i/
//   inst_rdata_i                    instruction memory interface
//   flush_i                         cancel everything queued or in flight
//   valid_o/pc_o/inst_o/exc_o/
//   exccode_o/ready_i               decode side show-ahead head
//   count_o                         FIFO occupancy
module inst_fetch_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pc_valid_i,
  input  logic [31:0]              pc_i,
  input  logic                     pc_exc_i,
  input  logic [4:0]               pc_exccode_i,
  output logic                     pc_ready_o,
  output logic                     inst_req_o,
  output logic [31:0]              inst_addr_o,
  input  logic                     inst_addr_ok_i,
  input  logic                     inst_data_ok_i,
  input  logic [31:0]              inst_rdata_i,
  input  logic                     flush_i,
  output logic                     valid_o,
  output logic [31:0]              pc_o,
  output logic [31:0]              inst_o,
  output logic                     exc_o,
  output logic [4:0]               exccode_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [4:0]  code;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   cnt;

  logic [31:0]     pend [MAX_OUTSTANDING];
  logic [PW-1:0]   pwptr, prptr;

  logic [OW-1:0]   outs, disc, live, outs_nxt;

  logic            issue_ok, req_cand, accept, exc_enq, resp_keep;
  logic            push, pop;
  entry_t          push_data;

  // pending-PC pointers wrap at MAX_OUTSTANDING
  function automatic logic [PW-1:0] pinc(input logic [PW-1:0] p);
    pinc = (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // live = requests whose responses will actually be kept
  assign live     = outs - disc;
  // reserve a FIFO slot for every live request so responses never overflow
  assign issue_ok = (SW'(cnt) + SW'(live) < SW'(DEPTH)) &&
                    (outs < OW'(MAX_OUTSTANDING));
  assign req_cand = pc_valid_i && !pc_exc_i && issue_ok;

  assign inst_req_o  = req_cand && !flush_i && !reset;
  assign inst_addr_o = pc_i;
  // an acceptance during flush still creates a response that must be dropped
  assign accept      = inst_addr_ok_i && req_cand && !reset;
  // exception PCs wait until every older live request has landed (keeps order)
  assign exc_enq     = pc_valid_i && pc_exc_i && (live == '0) &&
                       (cnt < CW'(DEPTH)) && !flush_i && !reset;
  assign pc_ready_o  = (accept && !flush_i) || exc_enq;

  assign resp_keep = inst_data_ok_i && (disc == '0);
  assign push      = !flush_i && (resp_keep || exc_enq);
  assign pop       = valid_o && ready_i;
  assign push_data = exc_enq ? entry_t'{pc_i, 32'd0, 1'b1, pc_exccode_i}
                             : entry_t'{pend[prptr], inst_rdata_i, 1'b0, 5'd0};

  assign outs_nxt = outs + OW'(accept) - OW'(inst_data_ok_i);

  assign valid_o   = (cnt != '0) && !flush_i;
  assign pc_o      = fifo[rptr].pc;
  assign inst_o    = fifo[rptr].inst;
  assign exc_o     = fifo[rptr].exc;
  assign exccode_o = fifo[rptr].code;
  assign count_o   = cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) pend[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      pwptr <= '0;
      prptr <= '0;
      outs  <= '0;
      disc  <= '0;
    end else begin
      outs <= outs_nxt;
      if (flush_i) begin
        // everything still in flight after this edge belongs to the old path
        disc  <= outs_nxt;
        wptr  <= '0;
        rptr  <= '0;
        cnt   <= '0;
        pwptr <= '0;
        prptr <= '0;
      end else begin
        if (inst_data_ok_i && disc != '0) disc <= disc - 1'b1;
        if (push) begin
          fifo[wptr] <= push_data;
          wptr       <= wptr + 1'b1;
        end
        if (pop) rptr <= rptr + 1'b1;
        cnt <= cnt + CW'(push) - CW'(pop);
        if (accept) begin
          pend[pwptr] <= pc_i;
          pwptr       <= pinc(pwptr);
        end
        if (resp_keep) prptr <= pinc(prptr);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && cnt == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && cnt == '0));
  a_disc_le_outs: assert property (@(posedge clk) disable iff (reset)
    disc <= outs);
  a_pend_nonempty: assert property (@(posedge clk) disable iff (reset)
    !(resp_keep && !flush_i && live == '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
`timescale 1ns/1ps
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_valid_i;
  logic [31:0] pc_i;
  logic        pc_exc_i;
  logic [4:0]  pc_exccode_i;
  logic        pc_ready_o;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i;
  logic        inst_data_ok_i;
  logic [31:0] inst_rdata_i;
  logic        flush_i;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        exc_o;
  logic [4:0]  exccode_o;
  logic        ready_i;
  logic [2:0]  count_o;

  inst_fetch_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .pc_valid_i(pc_valid_i), .pc_i(pc_i), .pc_exc_i(pc_exc_i),
    .pc_exccode_i(pc_exccode_i), .pc_ready_o(pc_ready_o),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
    .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
    .inst_rdata_i(inst_rdata_i), .flush_i(flush_i),
    .valid_o(valid_o), .pc_o(pc_o), .inst_o(inst_o), .exc_o(exc_o),
    .exccode_o(exccode_o), .ready_i(ready_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic exc; logic [4:0] code; } fq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic exc; logic [4:0] code; } ex_t;
  typedef struct { logic [31:0] addr; int due; } mr_t;

  fq_t fq[$];   // fetch model: PCs waiting to be presented
  mr_t mq[$];   // memory model: accepted requests awaiting response
  ex_t sb[$];   // scoreboard: expected decode-side entries

  int n_cmp = 0, n_err = 0;
  int cyc_n = 0, lat = 1, nacc = 0;
  logic mem_rdy = 1'b1, force_aok = 1'b0;
  logic last_valid, last_req, last_prdy;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic add_pc(input logic [31:0] pc, input logic exc, input logic [4:0] code);
    fq_t e;
    e.pc = pc; e.exc = exc; e.code = code;
    fq.push_back(e);
  endtask

  // One cycle: drive inputs, settle, account handshakes, then cross the posedge.
  task automatic tick();
    ex_t e, h;
    mr_t m;
    if (fq.size() > 0) begin
      pc_valid_i = 1'b1; pc_i = fq[0].pc; pc_exc_i = fq[0].exc; pc_exccode_i = fq[0].code;
    end else begin
      pc_valid_i = 1'b0; pc_i = '0; pc_exc_i = 1'b0; pc_exccode_i = '0;
    end
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      inst_data_ok_i = 1'b1; inst_rdata_i = mk(mq[0].addr);
    end else begin
      inst_data_ok_i = 1'b0; inst_rdata_i = '0;
    end
    #1;
    inst_addr_ok_i = (mem_rdy && inst_req_o) || force_aok;
    #1;
    last_valid = valid_o; last_req = inst_req_o; last_prdy = pc_ready_o;
    if (inst_data_ok_i) void'(mq.pop_front());
    if (inst_addr_ok_i) begin
      m.addr = inst_addr_o; m.due = cyc_n + lat;
      mq.push_back(m);
      if (!flush_i) nacc++;
    end
    if (valid_o && ready_i) begin
      if (sb.size() == 0) chk("unexpected_out", {31'd0, valid_o}, 32'd0);
      else begin
        h = sb.pop_front();
        chk("pc", pc_o, h.pc);
        chk("inst", inst_o, h.inst);
        chk("exc", {31'd0, exc_o}, {31'd0, h.exc});
        chk("exccode", {27'd0, exccode_o}, {27'd0, h.code});
      end
    end
    if (flush_i) sb.delete();
    if (pc_ready_o) begin
      e.pc = pc_i; e.exc = pc_exc_i;
      e.inst = pc_exc_i ? 32'd0 : mk(pc_i);
      e.code = pc_exc_i ? pc_exccode_i : 5'd0;
      sb.push_back(e);
      void'(fq.pop_front());
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((fq.size() + mq.size() + sb.size()) != 0 && k < budget) begin
      tick(); k++;
    end
    chk("drain_left", fq.size() + mq.size() + sb.size(), 0);
  endtask

  initial begin
    int nv;
    reset = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
    pc_valid_i = 1'b0; pc_i = '0; pc_exc_i = 1'b0; pc_exccode_i = '0;
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = '0;
    #2;
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_count", {29'd0, count_o}, 0);
    chk("rst_req", {31'd0, inst_req_o}, 0);
    chk("rst_prdy", {31'd0, pc_ready_o}, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_inst", inst_o, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // 1: stream, 1-cycle latency, decode always ready
    ready_i = 1'b1; lat = 1;
    add_pc(32'h100, 0, 0); add_pc(32'h104, 0, 0); add_pc(32'h108, 0, 0);
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_valid", {31'd0, last_valid}, 1);
    end
    drain(20);

    // 2: decode stalled -> credit limits issue to DEPTH
    ready_i = 1'b0; nacc = 0;
    for (int i = 0; i < 8; i++) add_pc(32'h1000 + 32'(i * 4), 0, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("t2_nacc", nacc, 4);
    chk("t2_count", {29'd0, count_o}, 4);
    chk("t2_req", {31'd0, last_req}, 0);
    ready_i = 1'b1;
    tick();
    chk("t2_nacc_pop1", nacc, 4);
    tick();
    chk("t2_nacc_pop2", nacc, 5);
    drain(40);

    // 3: flush with two requests in flight
    lat = 3;
    add_pc(32'h180, 0, 0); add_pc(32'h184, 0, 0);
    tick(); tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    add_pc(32'h200, 0, 0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (last_valid) nv++;
    end
    chk("t3_novalid", nv, 0);
    drain(30);

    // 4: flush coinciding with addr_ok and data_ok, one request outstanding
    lat = 1;
    add_pc(32'h3f0, 0, 0);
    tick();
    add_pc(32'h3f8, 0, 0);
    flush_i = 1'b1; force_aok = 1'b1;
    tick();
    flush_i = 1'b0; force_aok = 1'b0;
    fq.delete();
    add_pc(32'h400, 0, 0);
    drain(30);

    // 5: exception PC held behind an in-flight request
    lat = 3;
    add_pc(32'h2fc, 0, 0); add_pc(32'h300, 1, 5'd4);
    tick();
    tick();
    chk("t5_hold_a", {31'd0, last_prdy}, 0);
    tick();
    chk("t5_hold_b", {31'd0, last_prdy}, 0);
    drain(30);

    // 6: asynchronous reset mid-stream
    ready_i = 1'b0; lat = 4;
    for (int i = 0; i < 6; i++) add_pc(32'h500 + 32'(i * 4), 0, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_pre_count", {31'd0, count_o != 0}, 1);
    pc_valid_i = 1'b1; pc_i = 32'h600; pc_exc_i = 1'b0;
    inst_data_ok_i = 1'b0; inst_addr_ok_i = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("t6_valid", {31'd0, valid_o}, 0);
    chk("t6_count", {29'd0, count_o}, 0);
    chk("t6_req", {31'd0, inst_req_o}, 0);
    fq.delete(); mq.delete(); sb.delete();
    @(negedge clk);
    reset = 1'b0;
    ready_i = 1'b1; lat = 1;
    add_pc(32'hbfc0_0000, 0, 0); add_pc(32'hbfc0_0004, 0, 0);
    drain(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
